// File: rtl/uart_matrix_loader.sv
// -----------------------------------------------------------------------------
// uart_matrix_loader
//
// Frame parser between the UART byte receiver and the matrix-multiplier operand
// buffers. Recognises the packet
//   0xA5, DIM, N*N bytes of A, N*N bytes of B, CHK
// where CHK = (DIM + sum of all elements) mod 256. Elements are written
// row-major (addr = row*N + col) through a single-cycle write strobe. The
// validated dimension is published on `dim` once the checksum matches.
//
// Optional feature (compile-time macro UART_LOADER_TIMEOUT_EN):
//   An inter-byte timeout aborts a stalled frame after TIMEOUT_CYCLES cycles.
//   Without the macro a partial frame waits indefinitely.
//
// Parameters
//   MAX_DIM         largest accepted square dimension N (1..MAX_DIM)
//   ADDR_W          element address width, 2^ADDR_W >= MAX_DIM*MAX_DIM
//   TIMEOUT_CYCLES  inter-byte timeout (only with UART_LOADER_TIMEOUT_EN)
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   rxData      received byte, valid while rxDone is high
//   rxDone      receiver done level (may stay high for several cycles)
//   rxErr       receiver framing error, sampled with rxDone
//   wrEn        one-cycle operand buffer write strobe
//   wrSel       0 = matrix A, 1 = matrix B
//   wrAddr      element index row*N + col
//   wrData      element value
//   dim         last validated N, holds until the next valid frame
//   frameValid  one-cycle pulse: frame accepted, checksum correct
//   frameErr    one-cycle pulse: frame aborted or checksum wrong
//   busy        high whenever the parser is not idle
// -----------------------------------------------------------------------------
module uart_matrix_loader #(
  parameter int MAX_DIM        = 4,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rxData,
  input  logic              rxDone,
  input  logic              rxErr,
  output logic              wrEn,
  output logic              wrSel,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [7:0]        wrData,
  output logic [2:0]        dim,
  output logic              frameValid,
  output logic              frameErr,
  output logic              busy
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIM,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CHECK
  } state_t;

  // One bit wider than the address so N*N-1 never overflows the comparison.
  typedef logic [ADDR_W:0] wide_t;

  state_t              state, stateNext;
  logic                prevDone;
  logic [7:0]          sum, sumNext;
  logic [ADDR_W-1:0]   index, indexNext;
  logic [2:0]          nReg, nNext;
  logic [2:0]          dimNext;
  logic                wrEnNext, wrSelNext;
  logic [ADDR_W-1:0]   wrAddrNext;
  logic [7:0]          wrDataNext;
  logic                frameValidNext, frameErrNext;
  logic                byteEvent;
  logic                lastIndex;
  logic                dimOk;
  logic                timeoutHit;
  wide_t               nSqMinus1;

  // A byte is taken only on the rising edge of the receiver's done level.
  assign byteEvent = rxDone & ~prevDone;

  assign nSqMinus1 = wide_t'(nReg) * wide_t'(nReg) - wide_t'(1);
  assign lastIndex = (wide_t'(index) == nSqMinus1);
  assign dimOk     = (rxData != 8'd0) && (rxData <= 8'(MAX_DIM));

  assign busy = (state != ST_IDLE);

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] toCount;

  assign timeoutHit = (state != ST_IDLE) && (toCount == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || byteEvent || state == ST_IDLE) begin
      toCount <= '0;
    end else if (!timeoutHit) begin
      toCount <= toCount + 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    stateNext      = state;
    sumNext        = sum;
    indexNext      = index;
    nNext          = nReg;
    dimNext        = dim;
    wrEnNext       = 1'b0;
    wrSelNext      = wrSel;
    wrAddrNext     = wrAddr;
    wrDataNext     = wrData;
    frameValidNext = 1'b0;
    frameErrNext   = 1'b0;

    if (byteEvent) begin
      if (rxErr) begin
        // A corrupted byte aborts a frame in progress; in IDLE it is noise.
        if (state != ST_IDLE) begin
          frameErrNext = 1'b1;
          stateNext    = ST_IDLE;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (rxData == SYNC_BYTE) begin
              stateNext = ST_DIM;
            end
          end

          ST_DIM: begin
            if (dimOk) begin
              nNext     = rxData[2:0];
              sumNext   = rxData;
              indexNext = '0;
              stateNext = ST_LOAD_A;
            end else begin
              frameErrNext = 1'b1;
              stateNext    = ST_IDLE;
            end
          end

          ST_LOAD_A, ST_LOAD_B: begin
            wrEnNext   = 1'b1;
            wrSelNext  = (state == ST_LOAD_B);
            wrAddrNext = index;
            wrDataNext = rxData;
            sumNext    = sum + rxData;
            if (lastIndex) begin
              indexNext = '0;
              stateNext = (state == ST_LOAD_A) ? ST_LOAD_B : ST_CHECK;
            end else begin
              indexNext = index + 1'b1;
            end
          end

          ST_CHECK: begin
            if (rxData == sum) begin
              frameValidNext = 1'b1;
              dimNext        = nReg;
            end else begin
              frameErrNext = 1'b1;
            end
            stateNext = ST_IDLE;
          end

          default: stateNext = ST_IDLE;
        endcase
      end
    end else if (timeoutHit) begin
      // A byte arriving in the timeout cycle wins; only a silent cycle aborts.
      frameErrNext = 1'b1;
      stateNext    = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      // Reset high so a done level held through reset release is not a byte.
      prevDone   <= 1'b1;
      sum        <= '0;
      index      <= '0;
      nReg       <= '0;
      dim        <= '0;
      wrEn       <= 1'b0;
      wrSel      <= 1'b0;
      wrAddr     <= '0;
      wrData     <= '0;
      frameValid <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      state      <= stateNext;
      prevDone   <= rxDone;
      sum        <= sumNext;
      index      <= indexNext;
      nReg       <= nNext;
      dim        <= dimNext;
      wrEn       <= wrEnNext;
      wrSel      <= wrSelNext;
      wrAddr     <= wrAddrNext;
      wrData     <= wrDataNext;
      frameValid <= frameValidNext;
      frameErr   <= frameErrNext;
    end
  end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_matrix_loader
//
// Directed self-checking bench for uart_matrix_loader. Byte events are driven
// with a configurable rxDone hold time; a negedge monitor logs every write and
// counts frameValid / frameErr pulses. Expected values are hand-computed.
// Build with +define+UART_LOADER_TIMEOUT_EN to also exercise the timeout
// (the DUT is instantiated with TIMEOUT_CYCLES = 1000).
// -----------------------------------------------------------------------------
module tb_uart_matrix_loader;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rxData;
  logic              rxDone;
  logic              rxErr;
  logic              wrEn;
  logic              wrSel;
  logic [ADDR_W-1:0] wrAddr;
  logic [7:0]        wrData;
  logic [2:0]        dim;
  logic              frameValid;
  logic              frameErr;
  logic              busy;

  uart_matrix_loader #(
    .MAX_DIM        (4),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxData     (rxData),
    .rxDone     (rxDone),
    .rxErr      (rxErr),
    .wrEn       (wrEn),
    .wrSel      (wrSel),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .dim        (dim),
    .frameValid (frameValid),
    .frameErr   (frameErr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state, written only by the monitor process.
  logic              selLog[$];
  logic [ADDR_W-1:0] addrLog[$];
  logic [7:0]        dataLog[$];
  int                fvCount = 0;
  int                feCount = 0;
  logic [2:0]        dimAtValid = '0;

  logic [7:0] frm[$];

  always @(negedge clk) begin
    if (wrEn) begin
      selLog.push_back(wrSel);
      addrLog.push_back(wrAddr);
      dataLog.push_back(wrData);
    end
    if (frameValid) begin
      fvCount++;
      dimAtValid = dim;
    end
    if (frameErr) feCount++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] d, input logic e, input int hold);
    @(posedge clk);
    #1;
    rxData = d;
    rxErr  = e;
    rxDone = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    rxDone = 1'b0;
    rxErr  = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic sendFrame(input int hold);
    foreach (frm[i]) sendByte(frm[i], 1'b0, hold);
    @(negedge clk);
  endtask

  // Compares logged writes starting at base against a sel/addr/data triple.
  task automatic checkWrite(input string tag, input int idx,
                            input logic sel, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] data);
    check({tag, ".sel"},  32'(selLog[idx]),  32'(sel));
    check({tag, ".addr"}, 32'(addrLog[idx]), 32'(addr));
    check({tag, ".data"}, 32'(dataLog[idx]), 32'(data));
  endtask

  initial begin
    int wrBase, fvBase, feBase;

    rst    = 1'b1;
    rxData = '0;
    rxDone = 1'b0;
    rxErr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst.wrEn",       32'(wrEn),       32'd0);
    check("rst.wrSel",      32'(wrSel),      32'd0);
    check("rst.wrAddr",     32'(wrAddr),     32'd0);
    check("rst.wrData",     32'(wrData),     32'd0);
    check("rst.dim",        32'(dim),        32'd0);
    check("rst.frameValid", 32'(frameValid), 32'd0);
    check("rst.frameErr",   32'(frameErr),   32'd0);
    check("rst.busy",       32'(busy),       32'd0);

    // Good DIM=2 frame: A = 1..4, B = 5..8, CHK = 2+36 = 0x26.
    wrBase = selLog.size(); fvBase = fvCount; feBase = feCount;
    sendByte(8'hA5, 1'b0, 1);
    check("good.busyAfterSync", 32'(busy), 32'd1);
    frm = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h26};
    sendFrame(1);
    check("good.writes", 32'(selLog.size() - wrBase), 32'd8);
    checkWrite("good.w0", wrBase + 0, 1'b0, 4'd0, 8'h01);
    checkWrite("good.w1", wrBase + 1, 1'b0, 4'd1, 8'h02);
    checkWrite("good.w2", wrBase + 2, 1'b0, 4'd2, 8'h03);
    checkWrite("good.w3", wrBase + 3, 1'b0, 4'd3, 8'h04);
    checkWrite("good.w4", wrBase + 4, 1'b1, 4'd0, 8'h05);
    checkWrite("good.w5", wrBase + 5, 1'b1, 4'd1, 8'h06);
    checkWrite("good.w6", wrBase + 6, 1'b1, 4'd2, 8'h07);
    checkWrite("good.w7", wrBase + 7, 1'b1, 4'd3, 8'h08);
    check("good.frameValid", 32'(fvCount - fvBase), 32'd1);
    check("good.frameErr",   32'(feCount - feBase), 32'd0);
    check("good.dimAtPulse", 32'(dimAtValid),       32'd2);
    check("good.dim",        32'(dim),              32'd2);
    check("good.busyEnd",    32'(busy),             32'd0);

    // Same frame with wrong checksum 0x27.
    wrBase = selLog.size(); fvBase = fvCount; feBase = feCount;
    frm = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h27};
    sendFrame(1);
    check("badChk.writes",     32'(selLog.size() - wrBase), 32'd8);
    checkWrite("badChk.w7", wrBase + 7, 1'b1, 4'd3, 8'h08);
    check("badChk.frameErr",   32'(feCount - feBase), 32'd1);
    check("badChk.frameValid", 32'(fvCount - fvBase), 32'd0);
    check("badChk.dimHeld",    32'(dim),              32'd2);
    check("badChk.busyEnd",    32'(busy),             32'd0);

    // Noise in IDLE, then an out-of-range dimension.
    wrBase = selLog.size(); fvBase = fvCount; feBase = feCount;
    frm = '{8'h00, 8'hFF};
    sendFrame(1);
    check("noise.busy",     32'(busy),              32'd0);
    check("noise.frameErr", 32'(feCount - feBase),  32'd0);
    frm = '{8'hA5, 8'h05};
    sendFrame(1);
    check("dimBad.frameErr",   32'(feCount - feBase),        32'd1);
    check("dimBad.busy",       32'(busy),                    32'd0);
    check("dimBad.writes",     32'(selLog.size() - wrBase),  32'd0);
    check("dimBad.frameValid", 32'(fvCount - fvBase),        32'd0);

    // rxDone held 50 cycles per byte: DIM=1, A=09, B=0A, CHK=0x14.
    wrBase = selLog.size(); fvBase = fvCount; feBase = feCount;
    frm = '{8'hA5, 8'h01, 8'h09, 8'h0A, 8'h14};
    sendFrame(50);
    check("hold.writes", 32'(selLog.size() - wrBase), 32'd2);
    checkWrite("hold.w0", wrBase + 0, 1'b0, 4'd0, 8'h09);
    checkWrite("hold.w1", wrBase + 1, 1'b1, 4'd0, 8'h0A);
    check("hold.frameValid", 32'(fvCount - fvBase), 32'd1);
    check("hold.frameErr",   32'(feCount - feBase), 32'd0);
    check("hold.dim",        32'(dim),              32'd1);

    // rxErr on the third A byte of a DIM=2 frame.
    wrBase = selLog.size(); fvBase = fvCount; feBase = feCount;
    frm = '{8'hA5, 8'h02, 8'h01, 8'h02};
    sendFrame(1);
    sendByte(8'h03, 1'b1, 1);
    @(negedge clk);
    check("rxErr.frameErr", 32'(feCount - feBase),       32'd1);
    check("rxErr.writes",   32'(selLog.size() - wrBase), 32'd2);
    check("rxErr.busy",     32'(busy),                   32'd0);
    check("rxErr.dimHeld",  32'(dim),                    32'd1);
    // Recovery with the good DIM=2 frame.
    fvBase = fvCount;
    frm = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h26};
    sendFrame(1);
    check("recover.frameValid", 32'(fvCount - fvBase), 32'd1);
    check("recover.dim",        32'(dim),              32'd2);

    // Reset mid-frame with rxDone held high through reset release.
    frm = '{8'hA5, 8'h03};
    sendFrame(1);
    check("midRst.busyBefore", 32'(busy), 32'd1);
    wrBase = selLog.size(); fvBase = fvCount; feBase = feCount;
    @(posedge clk);
    #1;
    rxData = 8'hA5;
    rxDone = 1'b1;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midRst.busy",     32'(busy),     32'd0);
    check("midRst.dim",      32'(dim),      32'd0);
    check("midRst.wrEn",     32'(wrEn),     32'd0);
    check("midRst.frameErr", 32'(frameErr), 32'd0);
    repeat (5) @(negedge clk);
    check("midRst.noEvent",   32'(busy),                    32'd0);
    check("midRst.writes",    32'(selLog.size() - wrBase),  32'd0);
    check("midRst.errPulses", 32'(feCount - feBase),        32'd0);
    rxDone = 1'b0;
    // DIM=1 frame after reset: 1+7+8 = 0x10.
    frm = '{8'hA5, 8'h01, 8'h07, 8'h08, 8'h10};
    sendFrame(1);
    check("postRst.frameValid", 32'(fvCount - fvBase), 32'd1);
    check("postRst.dim",        32'(dim),              32'd1);

`ifdef UART_LOADER_TIMEOUT_EN
    // Stalled frame: the counter clears at the end of the last byte's edge
    // cycle E, reaches 999 during E+1000, so frameErr is high in E+1001.
    begin
      int n;
      bit seen;
      feBase = feCount;
      frm = '{8'hA5, 8'h02};
      sendFrame(1);
      @(posedge clk);
      #1;
      rxData = 8'h01;
      rxDone = 1'b1;
      @(posedge clk);
      #1;
      rxDone = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 2000) begin
        @(negedge clk);
        n++;
        if (frameErr) seen = 1'b1;
      end
      check("timeout.seen",   32'(seen), 32'd1);
      check("timeout.cycles", 32'(n),    32'd1001);
      @(negedge clk);
      check("timeout.busy",   32'(busy), 32'd0);
      check("timeout.pulses", 32'(feCount - feBase), 32'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_matrix_loader.md
# uart_matrix_loader

Frame parser that sits directly downstream of the UART 8-bit receiver in the matrix-multiplier datapath. Consumes received bytes and their done/error flags, and recognises a framed matrix-pair packet. Writes matrix A and matrix B elements, row-major, into the operand buffers through a simple write port. Reports a validated dimension once the packet checksum matches.

## Interface
Parameters:
- MAX_DIM, 4: largest accepted square dimension N (1..MAX_DIM).
- ADDR_W, 4: element address width; must satisfy 2^ADDR_W >= MAX_DIM*MAX_DIM.
- TIMEOUT_CYCLES, 100000000: inter-byte timeout in clk cycles. Used only with UART_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rxData  in  8  receiver byte output; valid while rxDone is high.
- rxDone  in  1  receiver done level; may stay high for several clk cycles.
- rxErr  in  1  receiver framing error, sampled with rxDone.
- wrEn  out  1  one-cycle write strobe to operand buffer.
- wrSel  out  1  0 = matrix A, 1 = matrix B.
- wrAddr  out  ADDR_W  element index, row*N + col.
- wrData  out  8  element value.
- dim  out  3  last validated N; holds until the next valid frame.
- frameValid  out  1  one-cycle pulse: frame accepted, checksum correct.
- frameErr  out  1  one-cycle pulse: frame aborted or checksum wrong.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Frame format: 0xA5 sync, DIM byte, N*N A bytes, N*N B bytes, CHK byte.
  - CHK = (DIM + sum of all 2*N*N elements) mod 256.
- Byte event:
  - Detected on the rising edge of rxDone, using a prev_rxDone register.
  - The edge cycle is E: rxDone=1 and prev_rxDone=0.
  - If rxErr=1 at E, the byte is discarded.
- States: IDLE, DIM, LOAD_A, LOAD_B, CHECK.
- IDLE:
  - Byte 0xA5 -> DIM. Any other byte is ignored silently; no frameErr.
- DIM:
  - Byte in 1..MAX_DIM -> latch N, clear sum to the DIM value, clear index -> LOAD_A.
  - Byte 0 or >MAX_DIM -> frameErr, go to IDLE.
- LOAD_A / LOAD_B, per byte:
  - wrEn pulse with the current wrSel and wrAddr=index.
  - sum += byte, index++.
  - After index N*N-1: LOAD_A -> LOAD_B with index cleared; LOAD_B -> CHECK.
- CHECK:
  - Byte == sum -> frameValid pulse, dim <= N.
  - Byte != sum -> frameErr pulse.
  - Both cases -> IDLE.
- rxErr byte in any non-IDLE state: frameErr pulse, go to IDLE. In IDLE it is ignored.
- Buffer contents may be partially overwritten by a bad frame. Downstream uses the buffers only after frameValid.
- Arithmetic: sum is 8-bit, wraps mod 256. Index is ADDR_W bits and never exceeds N*N-1.

## Timing
- Reset values:
  - All outputs 0, dim=0, state IDLE, sum=0, index=0.
  - prev_rxDone=1, so an rxDone level held high across reset release does not create a byte event.
- Latency:
  - wrEn, wrAddr, wrData and wrSel are registered and valid during cycle E+1, for exactly one cycle.
  - frameValid and frameErr are high during E+1 of the triggering byte.
  - dim updates in the same cycle as frameValid.
- The remaining registered outputs update at the end of cycle E:
  - busy rises at E+1 of the sync byte.
  - busy falls at E+1 of the CHK byte, or of the aborting byte.
- rxDone held high for many cycles still counts as one event. A new event requires rxDone to go low first.
- rst mid-frame: immediate return to IDLE. No frameErr and no wrEn in the cycle after reset.
- No backpressure: the write port must accept a write on any cycle. Minimum byte spacing is one UART character time.

## Configuration
- UART_LOADER_TIMEOUT_EN defined:
  - A counter clears on each byte event and runs while state != IDLE.
  - When it reaches TIMEOUT_CYCLES-1: frameErr pulse, go to IDLE.
  - A byte event in the same cycle as timeout takes priority and is processed normally.
- Not defined: no counter. A partial frame waits indefinitely for more bytes; only rst or an error byte clears it.

## Test plan
- Good frame A5,02,01,02,03,04,05,06,07,08,26 -> eight wrEn pulses:
  - wrSel=0 at addr 0..3 with data 1..4.
  - wrSel=1 at addr 0..3 with data 5..8.
  - Then frameValid=1 and dim=2, with no frameErr.
- Same frame with CHK=0x27 -> same eight writes, then a frameErr pulse. frameValid stays 0 and dim keeps its previous value.
- Bytes 00,FF,A5,05 with MAX_DIM=4:
  - 00 and FF are ignored.
  - 05 causes a frameErr pulse, busy returns to 0, and no wrEn occurs.
- rxDone held high for 50 cycles on each byte of the frame A5,01,09,0A,14 -> exactly two wrEn pulses, then frameValid (0x01+0x09+0x0A=0x14).
- rxErr=1 on the third A byte of a DIM=2 frame -> frameErr, IDLE, and exactly two wrEn pulses. A following good frame is then accepted.
- rst asserted after the DIM byte, with rxDone held high through reset release -> outputs 0, no spurious event. With UART_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=1000, a stalled frame gives frameErr 1000 cycles after its last byte.
